// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and types for the instruction memory loader.
// Optional checksum trailer is enabled with the LOADER_CHECKSUM_EN macro.
package instr_mem_loader_pkg;

    localparam int DEFAULT_DEPTH  = 128;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4,
        ST_DONE = 3'd5
    } loader_state_e;

    // States in which the loader consumes bytes and reports itself busy.
    function automatic logic is_loading(input loader_state_e s);
        logic r;
        case (s)
            ST_HDR0, ST_HDR1, ST_DATA, ST_CHK: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] place_byte(input logic [31:0] w,
                                               input logic [LANE_W-1:0] lane,
                                               input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/instr_mem_loader_byte_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words; word_valid marks the
// byte that completes a word, with word_data already holding all four lanes.
module instr_mem_loader_byte_word_assembler
    import instr_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       word_q, word_d;

    assign word_data  = place_byte(word_q, lane_q, byte_data);
    assign word_valid = byte_valid && !clear && (lane_q == LAST_LANE);

    // Next lane and partial word; the lane counter wraps after the last byte.
    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        if (clear) begin
            lane_d = '0;
            word_d = 32'h0000_0000;
        end else if (byte_valid) begin
            lane_d = lane_q + LANE_W'(1);
            word_d = word_data;
        end else begin
            lane_d = lane_q;
            word_d = word_q;
        end
    end

    // Lane and partial word registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= '0;
            word_q <= 32'h0000_0000;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed byte image into instruction memory and holds the CPU
// in reset until a clean load completes. LOADER_CHECKSUM_EN adds an XOR trailer.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        Start,
    input  logic [7:0]  Rx_Data,
    input  logic        Rx_Valid,
    output logic        Rx_Ready,
    output logic        IM_WE,
    output logic [31:0] IM_WA,
    output logic [31:0] IM_WD,
    output logic        Load_Busy,
    output logic        Load_Done,
    output logic        Load_Err,
    output logic        CPU_Hold
);

    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e ST_AFTER = ST_CHK;
`else
    localparam loader_state_e ST_AFTER = ST_DONE;
`endif

    loader_state_e    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic             err_q, err_d;
    logic             rx_ready_q, rx_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hold_q, hold_d;
    logic             we_q, we_d;
    logic [31:0]      wa_q, wa_d;
    logic [31:0]      wd_q, wd_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic             accept_s;
    logic             start_ok_s;
    logic             word_valid_s;
    logic [31:0]      word_data_s;
    logic [CNT_W-1:0] count_full_s;
    logic             in_range_s;

    assign accept_s     = Rx_Valid && rx_ready_q;
    assign start_ok_s   = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign count_full_s = CNT_W'({Rx_Data, count_q[7:0]});
    assign in_range_s   = ({1'b0, index_q} < DEPTH_LIM);

    instr_mem_loader_byte_word_assembler u_asm (
        .clk        (CLK),
        .rst_n      (RESETn),
        .clear      (start_ok_s),
        .byte_valid (accept_s && (state_q == ST_DATA)),
        .byte_data  (Rx_Data),
        .word_valid (word_valid_s),
        .word_data  (word_data_s)
    );

    // Next-state, counters, error and the registered output values.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        err_d   = err_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    state_d = ST_HDR0;
                    count_d = '0;
                    index_d = '0;
                    err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_HDR0: begin
                if (accept_s) begin
                    count_d = {count_q[CNT_W-1:8], Rx_Data};
                    state_d = ST_HDR1;
                end else begin
                    state_d = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (accept_s) begin
                    count_d = count_full_s;
                    if (count_full_s == '0) begin
                        state_d = ST_AFTER;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_HDR1;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ Rx_Data;
`endif
                    if (word_valid_s) begin
                        index_d = index_q + CNT_W'(1);
                        // Out-of-range words are swallowed so the stream stays aligned.
                        if (in_range_s) begin
                            we_d = 1'b1;
                            wa_d = {{(32 - CNT_W - 2){1'b0}}, index_q, 2'b00};
                            wd_d = word_data_s;
                        end else begin
                            err_d = 1'b1;
                        end
                        if (index_q == (count_q - CNT_W'(1))) begin
                            state_d = ST_AFTER;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept_s) begin
                    if (Rx_Data != csum_q) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CHK;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rx_ready_d = is_loading(state_d);
        busy_d     = is_loading(state_d);
        done_d     = (state_d == ST_DONE);
        hold_d     = !((state_d == ST_DONE) && !err_d);
    end

    // State and output registers; reset leaves memory contents alone.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            index_q    <= '0;
            err_q      <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hold_q     <= 1'b1;
            we_q       <= 1'b0;
            wa_q       <= 32'h0000_0000;
            wd_q       <= 32'h0000_0000;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            err_q      <= err_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hold_q     <= hold_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign Rx_Ready  = rx_ready_q;
    assign IM_WE     = we_q;
    assign IM_WA     = wa_q;
    assign IM_WD     = wd_q;
    assign Load_Busy = busy_q;
    assign Load_Done = done_q;
    assign Load_Err  = err_q;
    assign CPU_Hold  = hold_q;

endmodule
